hazard_controller: RTL and testbench
====================================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, giving the width of the stall and flush statistic counters.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port id_valid, input, 1 bit: the IF/ID stage holds a real instruction.
REQ-005 SHALL have ports id_rs and id_rt, input, 5 bits each: source register fields of the ID instruction.
REQ-006 SHALL have ports id_uses_rs and id_uses_rt, input, 1 bit each: the ID instruction reads rs or rt.
REQ-007 SHALL have ports id_regwrite and id_memread, input, 1 bit each: the ID instruction writes a register or is a load.
REQ-008 SHALL have port id_dest, input, 5 bits: destination register of the ID instruction after the RegDst/JAL mux.
REQ-009 SHALL have port ex_redirect, input, 1 bit: taken branch, J, JAL or JR resolved in EX.
REQ-010 SHALL have port clear_counters, input, 1 bit: synchronous clear of the statistic counters.
REQ-011 SHALL have port pc_enable, output, 1 bit: PC register load enable.
REQ-012 SHALL have port if_id_enable, output, 1 bit: IF/ID pipe enable.
REQ-013 SHALL have ports if_id_flush and id_ex_flush, output, 1 bit each: insert a bubble into IF/ID or ID/EX.
REQ-014 SHALL have ports fwd_a and fwd_b, output, 2 bits each: EX operand source; 00 register file, 10 EX/MEM result, 01 MEM/WB result.
REQ-015 SHALL have ports stall_count and flush_count, output, CNT_WIDTH bits each: statistic counters.

Function
REQ-016 SHALL keep a shadow pipeline of three stages (EX, MEM, WB), each holding valid, regwrite, memread and dest; the EX stage also holds rs, rt, uses_rs and uses_rt.
REQ-017 SHALL on every clock shift WB<=MEM and MEM<=EX, and load EX with the ID fields when issue=id_valid&!stall&!redirect, otherwise with a bubble (valid=0).
REQ-018 SHALL define redirect=ex_redirect&EX.valid; ex_redirect with EX.valid=0 SHALL be ignored.
REQ-019 SHALL define a hazard match against a stage as: stage.valid & stage.regwrite & stage.dest!=0 & reg==stage.dest; register $0 SHALL never cause a stall or a forward.
REQ-020 SHALL assert stall combinationally when !redirect & id_valid & EX.memread & (id_uses_rs & match(id_rs,EX) | id_uses_rt & match(id_rt,EX)).
REQ-021 SHALL drive pc_enable=0, if_id_enable=0 and id_ex_flush=1 during stall; a load-use stall SHALL last exactly one cycle.
REQ-022 SHALL drive if_id_flush=1, id_ex_flush=1 and pc_enable=1 during redirect; redirect SHALL override stall in the same cycle.
REQ-023 SHALL otherwise drive pc_enable=1, if_id_enable=1 and both flushes to 0.
REQ-024 SHALL set fwd_a to 10 when EX.uses_rs & match(EX.rs,MEM) & !MEM.memread; else to 01 when EX.uses_rs & match(EX.rs,WB); else to 00. MEM SHALL take priority over WB.
REQ-025 SHALL derive fwd_b in the same way from EX.rt and EX.uses_rt.
REQ-026 SHALL increment stall_count once per stall cycle and flush_count once per redirect cycle, each saturating at all-ones without wrapping.
REQ-027 SHALL give clear_counters priority over increment: on a clear cycle both counters go to 0 and the event in that cycle is not counted.

Reset
REQ-028 SHALL, while reset=1 at a clock edge, clear all shadow valid bits and both counters; reset SHALL take priority over all other inputs, including mid-stall and mid-redirect.
REQ-029 SHALL present, in the cycle after reset: pc_enable=1, if_id_enable=1, both flushes=0, fwd_a=fwd_b=00, and both counters=0.

Verification
REQ-030 SHALL cover load-use: lw $t0 issued, then add $t1,$t0,$t2 (id_rs=8) -> one stall cycle (pc_enable=0, id_ex_flush=1), stall_count=1, then the add reaches EX with fwd_a=01.
REQ-031 SHALL cover ALU-ALU back-to-back: add $8 then sub using rt=8 -> no stall, fwd_b=10; with one unrelated instruction between them -> fwd_b=01.
REQ-032 SHALL cover $0: a writer to $0 followed by a reader of $0, with memread=1 -> no stall, fwd=00.
REQ-033 SHALL cover a redirect in the same cycle as a stall condition -> stall=0, if_id_flush=1, id_ex_flush=1, pc_enable=1, flush_count+1, stall_count unchanged.
REQ-034 SHALL cover saturation and clear: preload by 65535 stall cycles, then one more -> stall_count stays 0xFFFF; assert clear_counters together with a stall -> stall_count=0.
REQ-035 SHALL cover reset asserted during a stall -> next cycle pc_enable=1, all shadow stages invalid, counters 0.

Source files
------------

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - load-use stall, redirect flush and EX operand forwarding control for a 5-stage pipeline
module hazard_controller #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [4:0]           id_rs,
    input  logic [4:0]           id_rt,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic                 id_regwrite,
    input  logic                 id_memread,
    input  logic [4:0]           id_dest,
    input  logic                 ex_redirect,
    input  logic                 clear_counters,
    output logic                 pc_enable,
    output logic                 if_id_enable,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    // Shadow copy of the instructions now in EX, MEM and WB.
    logic       ex_valid, ex_regwrite, ex_memread, ex_uses_rs, ex_uses_rt;
    logic [4:0] ex_dest, ex_rs, ex_rt;
    logic       mem_valid, mem_regwrite, mem_memread;
    logic [4:0] mem_dest;
    logic       wb_valid, wb_regwrite;
    logic [4:0] wb_dest;

    logic redirect, stall, issue;

    // $0 is hardwired to zero, so a write to it never produces a dependency.
    function automatic logic hit(input logic v, input logic rw,
                                 input logic [4:0] dest, input logic [4:0] r);
        return v & rw & (dest != 5'd0) & (r == dest);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic use_reg, input logic [4:0] r,
                                           input logic m_v, input logic m_rw,
                                           input logic m_mr, input logic [4:0] m_dest,
                                           input logic w_v, input logic w_rw,
                                           input logic [4:0] w_dest);
        if (use_reg && hit(m_v, m_rw, m_dest, r) && !m_mr)
            return 2'b10;
        else if (use_reg && hit(w_v, w_rw, w_dest, r))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        redirect = ex_redirect & ex_valid;
        stall    = !redirect & id_valid & ex_memread &
                   ((id_uses_rs & hit(ex_valid, ex_regwrite, ex_dest, id_rs)) |
                    (id_uses_rt & hit(ex_valid, ex_regwrite, ex_dest, id_rt)));
        issue    = id_valid & !stall & !redirect;
    end

    always_comb begin
        pc_enable    = 1'b1;
        if_id_enable = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        if (redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (stall) begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_flush  = 1'b1;
        end
    end

    always_comb begin
        fwd_a = fwd_sel(ex_uses_rs, ex_rs, mem_valid, mem_regwrite, mem_memread, mem_dest,
                        wb_valid, wb_regwrite, wb_dest);
        fwd_b = fwd_sel(ex_uses_rt, ex_rt, mem_valid, mem_regwrite, mem_memread, mem_dest,
                        wb_valid, wb_regwrite, wb_dest);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            ex_uses_rs   <= 1'b0;
            ex_uses_rt   <= 1'b0;
            ex_dest      <= 5'd0;
            ex_rs        <= 5'd0;
            ex_rt        <= 5'd0;
            mem_valid    <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_memread  <= 1'b0;
            mem_dest     <= 5'd0;
            wb_valid     <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_dest      <= 5'd0;
        end else begin
            wb_valid     <= mem_valid;
            wb_regwrite  <= mem_regwrite;
            wb_dest      <= mem_dest;
            mem_valid    <= ex_valid;
            mem_regwrite <= ex_regwrite;
            mem_memread  <= ex_memread;
            mem_dest     <= ex_dest;
            ex_valid     <= issue;
            ex_regwrite  <= issue & id_regwrite;
            ex_memread   <= issue & id_memread;
            ex_uses_rs   <= issue & id_uses_rs;
            ex_uses_rt   <= issue & id_uses_rt;
            ex_dest      <= id_dest;
            ex_rs        <= id_rs;
            ex_rt        <= id_rt;
        end
    end

    // Counters saturate so a long run never reports a deceptively small total.
    always_ff @(posedge clk) begin
        if (reset || clear_counters) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && stall_count != '1)
                stall_count <= stall_count + 1'b1;
            if (redirect && flush_count != '1)
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed self-checking bench for hazard_controller against an instruction-history model
module tb_hazard_controller;
    localparam int W    = 8;
    localparam int MAXC = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread;
    logic [4:0]   id_rs, id_rt, id_dest;
    logic         ex_redirect, clear_counters;
    logic         pc_enable, if_id_enable, if_id_flush, id_ex_flush;
    logic [1:0]   fwd_a, fwd_b;
    logic [W-1:0] stall_count, flush_count;

    int total = 0;
    int bad   = 0;

    hazard_controller #(.CNT_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_dest(id_dest), .ex_redirect(ex_redirect),
        .clear_counters(clear_counters), .pc_enable(pc_enable), .if_id_enable(if_id_enable),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v, rw, mr, urs, urt;
        int dest, rs, rt;
    } ins_t;

    // hist[0] is the instruction that entered EX most recently, hist[1] the one before it, ...
    ins_t hist[$];
    int   m_stall, m_flush;

    function automatic ins_t bubble();
        ins_t b;
        b = '{v: 0, rw: 0, mr: 0, urs: 0, urt: 0, dest: 0, rs: 0, rt: 0};
        return b;
    endfunction

    function automatic bit writes(ins_t s, int r);
        return s.v && s.rw && s.dest != 0 && s.dest == r;
    endfunction

    function automatic bit m_redirect();
        return ex_redirect && hist[0].v;
    endfunction

    function automatic bit m_stall_now();
        if (m_redirect() || !id_valid || !hist[0].mr) return 0;
        return (id_uses_rs && writes(hist[0], id_rs)) || (id_uses_rt && writes(hist[0], id_rt));
    endfunction

    function automatic int m_src(bit use_reg, int r);
        if (!use_reg) return 0;
        if (writes(hist[1], r) && !hist[1].mr) return 2;
        if (writes(hist[2], r)) return 1;
        return 0;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic settle();
        bit s, r;
        #1;
        if (!reset) begin
            s = m_stall_now();
            r = m_redirect();
            check("pc_enable",    pc_enable,    !s);
            check("if_id_enable", if_id_enable, !s);
            check("if_id_flush",  if_id_flush,  r);
            check("id_ex_flush",  id_ex_flush,  s || r);
            check("fwd_a", fwd_a, m_src(hist[0].urs, hist[0].rs));
            check("fwd_b", fwd_b, m_src(hist[0].urt, hist[0].rt));
            check("stall_count", stall_count, m_stall);
            check("flush_count", flush_count, m_flush);
        end
    endtask

    task automatic tick();
        bit s, r;
        ins_t n;
        s = m_stall_now();
        r = m_redirect();
        n = bubble();
        if (id_valid && !s && !r)
            n = '{v: 1, rw: id_regwrite, mr: id_memread, urs: id_uses_rs, urt: id_uses_rt,
                  dest: id_dest, rs: id_rs, rt: id_rt};
        @(posedge clk);
        if (reset) begin
            hist = '{bubble(), bubble(), bubble()};
            m_stall = 0;
            m_flush = 0;
        end else begin
            hist.push_front(n);
            void'(hist.pop_back());
            if (clear_counters) begin
                m_stall = 0;
                m_flush = 0;
            end else begin
                if (s && m_stall < MAXC) m_stall++;
                if (r && m_flush < MAXC) m_flush++;
            end
        end
        #1;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic set_id(bit v, int rs, int rt, bit urs, bit urt, bit rw, bit mr, int dest);
        id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rs = urs; id_uses_rt = urt;
        id_regwrite = rw; id_memread = mr; id_dest = 5'(dest);
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic lw8();
        set_id(1, 29, 0, 1, 0, 1, 1, 8);
    endtask

    task automatic dep8();
        set_id(1, 8, 10, 1, 1, 1, 0, 9);
    endtask

    initial begin
        hist = '{bubble(), bubble(), bubble()};
        m_stall = 0; m_flush = 0;
        reset = 1; ex_redirect = 0; clear_counters = 0;
        nop();
        #1;
        tick(); tick();
        reset = 0;
        settle();
        check("rst_pc_enable", pc_enable, 1);
        check("rst_if_id_enable", if_id_enable, 1);
        check("rst_flushes", {if_id_flush, id_ex_flush}, 0);
        check("rst_fwd", {fwd_a, fwd_b}, 0);
        check("rst_counters", {stall_count, flush_count}, 0);
        tick();

        // load-use: lw $t0 then add $t1,$t0,$t2
        lw8(); step();
        dep8(); settle();
        check("lu_pc_enable", pc_enable, 0);
        check("lu_id_ex_flush", id_ex_flush, 1);
        tick();
        settle();
        check("lu_one_cycle", pc_enable, 1);
        check("lu_stall_count", stall_count, 1);
        tick();
        nop(); settle();
        check("lu_fwd_a", fwd_a, 2'b01);
        tick(); step(); step();

        // ALU-ALU back to back, then with one unrelated instruction between
        set_id(1, 1, 2, 1, 1, 1, 0, 8); step();
        set_id(1, 3, 8, 1, 1, 1, 0, 4); settle();
        check("alu_no_stall", pc_enable, 1);
        tick();
        nop(); settle();
        check("alu_fwd_b_mem", fwd_b, 2'b10);
        tick(); step(); step();
        set_id(1, 1, 2, 1, 1, 1, 0, 8); step();
        set_id(1, 5, 6, 1, 1, 1, 0, 7); step();
        set_id(1, 3, 8, 1, 1, 1, 0, 4); step();
        nop(); settle();
        check("alu_fwd_b_wb", fwd_b, 2'b01);
        tick(); step(); step();

        // $0 never stalls or forwards
        set_id(1, 29, 0, 1, 0, 1, 1, 0); step();
        set_id(1, 0, 0, 1, 1, 1, 0, 3); settle();
        check("r0_no_stall", pc_enable, 1);
        tick();
        nop(); settle();
        check("r0_fwd", {fwd_a, fwd_b}, 0);
        tick(); step(); step();

        // redirect coincident with a stall condition, then redirect with empty EX
        lw8(); step();
        dep8(); ex_redirect = 1; settle();
        check("rd_pc_enable", pc_enable, 1);
        check("rd_flushes", {if_id_flush, id_ex_flush}, 2'b11);
        tick();
        ex_redirect = 0; settle();
        check("rd_flush_count", flush_count, 1);
        check("rd_stall_count", stall_count, 1);
        nop(); ex_redirect = 1; step(); step();
        ex_redirect = 0;

        // short pseudo-random burst over a tiny register set
        for (int i = 0; i < 200; i++) begin
            set_id($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 3));
            ex_redirect = $urandom_range(0, 5) == 0;
            step();
        end
        ex_redirect = 0;
        nop(); step();
        clear_counters = 1; step();
        clear_counters = 0;

        // saturation of stall_count, then clear together with a stall
        for (int i = 0; i < MAXC + 1; i++) begin
            lw8(); step();
            dep8(); step();
        end
        settle();
        check("sat_stall_count", stall_count, MAXC);
        lw8(); step();
        dep8(); clear_counters = 1; settle();
        check("clr_stall_present", pc_enable, 0);
        tick();
        clear_counters = 0; nop(); settle();
        check("clr_stall_count", stall_count, 0);
        tick();

        // reset in the middle of a stall
        lw8(); step();
        dep8(); settle();
        check("rs_stall_before", pc_enable, 0);
        reset = 1; tick();
        reset = 0; ex_redirect = 1; settle();
        check("rs_pc_enable", pc_enable, 1);
        check("rs_ex_invalid", if_id_flush, 0);
        check("rs_counters", {stall_count, flush_count}, 0);
        tick();
        ex_redirect = 0; nop(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
